// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional macro EX_MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module ex_muldiv_unit #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          flush,
  output logic          stall_req,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          res_valid
);

  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d, negr_q, negr_d, div0_q, div0_d;
  logic            res_valid_q, res_valid_d;

  // Launch decode: absolute operands and result sign flags
  logic            is_muldiv, is_signed, is_div, a_neg, b_neg, last;
  logic [DW-1:0]   a_abs, b_abs;

  assign is_muldiv = op_valid & ~op[2];
  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign a_neg     = is_signed & src_a[DW-1];
  assign b_neg     = is_signed & src_b[DW-1];
  assign a_abs     = a_neg ? -src_a : src_a;
  assign b_abs     = b_neg ? -src_b : src_b;
  assign last      = (cnt_q == CW'(DW - 1));

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [DW:0]     mul_sum;
  logic [PW-1:0]   mul_acc, mul_res;
  // Restoring-divide step: acc = {remainder, dividend/quotient bits}
  logic [DW:0]     rem_sh, diff;
  logic            q_bit;
  logic [PW-1:0]   div_acc;
  logic [DW-1:0]   quo, rem;

  assign mul_sum = {1'b0, acc_q[PW-1:DW]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc = {mul_sum, acc_q[DW-1:1]};
  assign mul_res = neg_q ? -mul_acc : mul_acc;

  assign rem_sh  = {acc_q[PW-1:DW], acc_q[DW-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign q_bit   = ~diff[DW];
  assign div_acc = {(q_bit ? diff[DW-1:0] : rem_sh[DW-1:0]), acc_q[DW-2:0], q_bit};
  assign quo     = div_acc[DW-1:0];
  assign rem     = div_acc[PW-1:DW];

`ifdef EX_MULDIV_FAST_MUL_EN
  logic [PW-1:0]   fast_prod, fast_res;
  assign fast_prod = PW'(a_abs) * PW'(b_abs);
  assign fast_res  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_muldiv) begin
            if (is_div) state_d = S_DIV;
`ifdef EX_MULDIV_FAST_MUL_EN
            else        state_d = S_DONE;
`else
            else        state_d = S_MUL;
`endif
          end
        end
        S_MUL:   if (last) state_d = S_DONE;
        S_DIV:   if (last) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: launch-cycle stall is combinational so the issuing cycle holds
  always_comb begin
    stall_req   = ((state_q == S_IDLE) & is_muldiv) | (state_q == S_MUL) | (state_q == S_DIV);
    res_valid_d = (state_d == S_DONE);
  end

  // Datapath next values
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    negr_d = negr_q;
    div0_d = div0_q;
    if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (is_muldiv) begin
            a_d    = a_abs;
            b_d    = b_abs;
            neg_d  = a_neg ^ b_neg;
            negr_d = a_neg;
            div0_d = (src_b == '0);
            cnt_d  = '0;
            acc_d  = is_div ? {{DW{1'b0}}, a_abs} : {{DW{1'b0}}, b_abs};
`ifdef EX_MULDIV_FAST_MUL_EN
            if (!is_div) {hi_d, lo_d} = fast_res;
`endif
          end else if (op_valid && op == 3'd4) begin
            hi_d = src_a;
          end else if (op_valid && op == 3'd5) begin
            lo_d = src_a;
          end
        end
        S_MUL: begin
          acc_d = mul_acc;
          cnt_d = cnt_q + CW'(1);
          if (last) {hi_d, lo_d} = mul_res;
        end
        S_DIV: begin
          acc_d = div_acc;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            lo_d = div0_q ? '1 : (neg_q ? -quo : quo);
            hi_d = negr_q ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      negr_q      <= 1'b0;
      div0_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      negr_q      <= negr_d;
      div0_q      <= div0_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised and directed bench for ex_muldiv_unit against an arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [2:0]    op;
  logic [DW-1:0] src_a, src_b;
  logic          flush;
  logic          stall_req;
  logic [DW-1:0] hi, lo;
  logic          res_valid;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.DW(DW), .CW(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall_req(stall_req), .hi(hi), .lo(lo), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} from plain signed/unsigned arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (o)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: begin p = 64'(ua * ub); return p; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {32'(sr), 32'(sq)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] o);
`ifdef EX_MULDIV_FAST_MUL_EN
    if (o <= 3'd1) return 1;
`endif
    return DW + 1;
  endfunction

  // Issue one mul/div, hold op_valid through DONE, check latency, result and no relaunch
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          stalls;
    bit          got;
    logic [63:0] e;
    stalls = 0;
    got    = 0;
    e      = model(o, a, b);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (stall_req) stalls++;
      @(posedge clk); #1;
      if (res_valid) begin got = 1; break; end
    end
    chk("res_valid_seen", 64'(got), 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls(o)));
    chk("done_stall", 64'(stall_req), 64'd0);
    chk("hilo", {hi, lo}, e);
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    chk("pulse_end", 64'(res_valid), 64'd0);
    chk("no_relaunch", 64'(stall_req), 64'd0);
    chk("hilo_hold", {hi, lo}, e);
  endtask

  logic [63:0] saved;
  int          rv_seen;
  logic [31:0] ra, rb;
  logic [2:0]  ro;

  initial begin
    rst = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
    #12;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_rv", 64'(res_valid), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    @(negedge clk); rst = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op(3'd3, 32'h0000_0007, 32'h0000_0000);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    do_op(3'd1, 32'h0001_0000, 32'h0001_0000);
    do_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE);

    // MTHI then MTLO on consecutive edges
    @(negedge clk); op_valid = 1'b1; op = 3'd4; src_a = 32'h1234_5678;
    #1 chk("mthi_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_rv", 64'(res_valid), 64'd0);
    @(negedge clk); op = 3'd5; src_a = 32'h9ABC_DEF0;
    #1 chk("mtlo_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    chk("mtlo_rv", 64'(res_valid), 64'd0);

    // Reserved op: no stall, no effect
    @(negedge clk); op = 3'd6; src_a = 32'hDEAD_BEEF;
    #1 chk("rsvd_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    chk("rsvd_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    // Flush in IDLE suppresses MTHI and a launch
    @(negedge clk); op = 3'd4; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_mthi", 64'(hi), 64'h1234_5678);
    @(negedge clk); op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    #1 chk("flush_launch", 64'(stall_req), 64'd0);

    // DIVU flushed mid-flight
    saved = {hi, lo};
    @(negedge clk); op_valid = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); op_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_stall", 64'(stall_req), 64'd0);
    chk("flush_rv", 64'(res_valid), 64'd0);
    chk("flush_hilo", {hi, lo}, saved);
    rv_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (res_valid) rv_seen++; end
    chk("flush_no_rv", 64'(rv_seen), 64'd0);
    chk("flush_hilo_late", {hi, lo}, saved);

    // Reset mid-MULT clears HI/LO immediately
    do_op(3'd1, 32'h0000_1234, 32'h0000_5678);
    @(negedge clk); op_valid = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    repeat (5) @(posedge clk);
    @(negedge clk); op_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_stall", 64'(stall_req), 64'd0);
    chk("rst_mid_rv", 64'(res_valid), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Random mix with corner operands
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit attached to the EX stage of the 5-stage pipeline.
- Owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU iteratively, plus MTHI/MTLO.
- Raises stall_req so the stall controller holds IF..EX while an operation runs.
- HI/LO values feed the EX result mux for MFHI/MFLO.

Parameters:
DW, 32, operand/HI/LO width; power of two, >= 8
CW, 6, iteration counter width; must satisfy 2^CW > DW

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
op_valid  input  1  EX holds a valid HI/LO-class instruction this cycle
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no effect)
src_a  input  DW  rs operand (multiplicand/dividend; MTHI/MTLO data)
src_b  input  DW  rt operand (multiplier/divisor)
flush  input  1  cancel any operation in flight
stall_req  output  1  hold the pipeline
hi  output  DW  HI register
lo  output  DW  LO register
res_valid  output  1  one-cycle pulse when HI/LO are written by mul/div

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi=0, lo=0, res_valid=0, counter=0, internal accumulators=0. Reset mid-operation aborts with no HI/LO write.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_valid with op 0/1 -> MUL; op 2/3 -> DIV.
  - On launch, latch |src_a| and |src_b| (signed ops only; unsigned ops latch raw values), the result sign flags, and counter=0.
  - op 4/5: HI or LO <= src_a at this edge; state stays IDLE; no stall; res_valid stays 0.
- stall_req = (state==IDLE & op_valid & op<=3) | state==MUL | state==DIV. The first term is combinational, so the launch cycle stalls.
- MUL: one shift-add step per cycle over DW cycles; counter increments; after counter==DW-1 -> DONE.
- DIV: one restoring-subtract step per cycle over DW cycles; after counter==DW-1 -> DONE.
- DONE:
  - HI/LO written at the DONE entry edge; res_valid=1 for exactly this cycle; stall_req=0.
  - op_valid in DONE belongs to the completed instruction and is ignored (no relaunch).
  - Next edge -> IDLE.
- Latency: launch edge + DW iteration cycles; the instruction is stalled DW+1 cycles total; result visible in hi/lo in the DONE cycle.
- Multiply result: {hi,lo} = 2*DW-bit product. For MULT, negate the product when the operand signs differ.
- Divide result: lo=quotient, hi=remainder.
  - DIV: quotient negative when the operand signs differ; remainder takes the sign of the dividend.
  - Most-negative / -1: quotient = most-negative, remainder = 0 (wraps, no trap).
- Divide by zero (src_b==0): runs the full DW cycles; lo = all ones, hi = src_a (raw dividend). Both signed and unsigned.
- flush (synchronous, checked in any state): next state IDLE; hi/lo unchanged; res_valid=0. flush in IDLE suppresses a launch or MTHI/MTLO the same cycle. flush has priority over all other inputs.
- Reserved ops: ignored, no stall.
- Only one operation in flight; there is no queuing.

Optional Feature:
- Macro: EX_MULDIV_FAST_MUL_EN
- Defined:
  - MULT/MULTU computed by a single-cycle combinational multiplier.
  - Launch edge goes IDLE -> DONE directly; stall_req is high only in the launch cycle; hi/lo written at the next edge.
  - DIV is unchanged.
- Undefined: iterative multiply as specified above.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0x00000002 -> stall_req high 33 cycles, then res_valid pulse; hi=0x00000001, lo=0xFFFFFFFE.
- MULT src_a=0xFFFFFFFD (-3), src_b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
- MTHI 0x12345678, then next cycle MTLO 0x9ABCDEF0 -> hi/lo updated one edge each; stall_req never high; res_valid stays 0.
- DIVU launched, flush at iteration 10 -> IDLE next cycle, stall_req low, hi/lo keep prior values, no res_valid. rst=0 mid-MULT -> hi=lo=0 immediately.
- With EX_MULDIV_FAST_MUL_EN: MULTU 0x10000 x 0x10000 -> stall_req 1 cycle; hi=0x00000001, lo=0x00000000.
